// File: rtl/midi_pkg.sv
// Shared MIDI constants, byte classes and parser state encoding for the message parser.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CTRL     = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHAN_AT  = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   typedef enum logic [2:0] {
      CLS_DATA,
      CLS_CHAN,
      CLS_SYSEX,
      CLS_SYSCOM,
      CLS_RT
   } byteClass_t;

   typedef enum logic [2:0] {
      NOSTATUS,
      DATA1,
      DATA2,
      SYSEX,
      SKIP
   } parserState_t;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classifier: maps a received MIDI byte to its class and the
// number of data bytes that follow it (0, 1 or 2).
module midi_status_decode
   import midi_pkg::*;
(
   input  logic [7:0] byteIn,
   output byteClass_t byteClass,
   output logic [1:0] dataCount
);

   always_comb begin
      byteClass = CLS_DATA;
      dataCount = 2'd0;
      if (!byteIn[7]) begin
         byteClass = CLS_DATA;
      end else if (byteIn < SYSEX_START) begin
         byteClass = CLS_CHAN;
         dataCount = (byteIn[7:4] == PROG || byteIn[7:4] == CHAN_AT) ? 2'd1 : 2'd2;
      end else if (byteIn == SYSEX_START) begin
         byteClass = CLS_SYSEX;
      end else if (byteIn < RT_MIN) begin
         // Song position (F2) carries two bytes; MTC quarter frame and song select one.
         byteClass = CLS_SYSCOM;
         if (byteIn == 8'hF2)
            dataCount = 2'd2;
         else if (byteIn == 8'hF1 || byteIn == 8'hF3)
            dataCount = 2'd1;
      end else begin
         byteClass = CLS_RT;
      end
   end

endmodule

// File: rtl/midi_message_parser.sv
// Assembles MIDI channel-voice messages from the receiver byte strobe with running status.
// Build option MIDI_PARSER_REALTIME_EN enables the real-time byte strobe (rt_valid/rt_byte).
module midi_message_parser
   import midi_pkg::*;
#(
   parameter bit NOTE_ON_ZERO_AS_OFF = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       msg_valid,
   output logic [3:0] msg_type,
   output logic [3:0] msg_channel,
   output logic [6:0] msg_data1,
   output logic [6:0] msg_data2,
   output logic       rt_valid,
   output logic [7:0] rt_byte,
   output logic       err_pulse,
   output logic [7:0] err_count
);

   // Handshake: byte_valid is a one-cycle strobe qualifying byte_data; every
   // output strobe (msg_valid, rt_valid, err_pulse) is a registered one-cycle
   // pulse in the cycle after the causing byte, with no back-pressure.

   byteClass_t   byteClass;
   logic [1:0]   dataCount;
   parserState_t state;
   logic [3:0]   statusType;
   logic [3:0]   statusChan;
   logic         needTwo;
   logic [6:0]   data1Reg;
   logic [1:0]   skipCnt;
   logic         errNow;
   logic [3:0]   emitType;

   midi_status_decode uDecode (
      .byteIn    (byte_data),
      .byteClass (byteClass),
      .dataCount (dataCount)
   );

   always_comb begin
      errNow = 1'b0;
      if (byte_valid) begin
         errNow = (byteClass == CLS_CHAN && state == DATA2) ||
                  (byteClass == CLS_DATA && state == NOSTATUS);
      end
   end

   always_comb begin
      emitType = statusType;
      if (NOTE_ON_ZERO_AS_OFF && statusType == NOTE_ON && byte_data[6:0] == 7'd0)
         emitType = NOTE_OFF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= NOSTATUS;
         statusType  <= 4'd0;
         statusChan  <= 4'd0;
         needTwo     <= 1'b0;
         data1Reg    <= 7'd0;
         skipCnt     <= 2'd0;
         msg_valid   <= 1'b0;
         msg_type    <= 4'd0;
         msg_channel <= 4'd0;
         msg_data1   <= 7'd0;
         msg_data2   <= 7'd0;
         err_pulse   <= 1'b0;
         err_count   <= 8'd0;
      end else begin
         msg_valid <= 1'b0;
         err_pulse <= errNow;
         if (errNow && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         if (byte_valid) begin
            case (byteClass)
               CLS_CHAN: begin
                  statusType <= byte_data[7:4];
                  statusChan <= byte_data[3:0];
                  needTwo    <= (dataCount == 2'd2);
                  state      <= DATA1;
               end
               CLS_SYSEX: begin
                  statusType <= 4'd0;
                  statusChan <= 4'd0;
                  needTwo    <= 1'b0;
                  state      <= SYSEX;
               end
               CLS_SYSCOM: begin
                  // Also covers F7 closing a sysex block.
                  statusType <= 4'd0;
                  statusChan <= 4'd0;
                  needTwo    <= 1'b0;
                  skipCnt    <= dataCount;
                  state      <= (dataCount != 2'd0) ? SKIP : NOSTATUS;
               end
               CLS_DATA: begin
                  case (state)
                     DATA1: begin
                        if (needTwo) begin
                           data1Reg <= byte_data[6:0];
                           state    <= DATA2;
                        end else begin
                           msg_valid   <= 1'b1;
                           msg_type    <= statusType;
                           msg_channel <= statusChan;
                           msg_data1   <= byte_data[6:0];
                           msg_data2   <= 7'd0;
                        end
                     end
                     DATA2: begin
                        msg_valid   <= 1'b1;
                        msg_type    <= emitType;
                        msg_channel <= statusChan;
                        msg_data1   <= data1Reg;
                        msg_data2   <= byte_data[6:0];
                        state       <= DATA1;
                     end
                     SKIP: begin
                        skipCnt <= skipCnt - 2'd1;
                        if (skipCnt == 2'd1)
                           state <= NOSTATUS;
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MIDI_PARSER_REALTIME_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rt_valid <= 1'b0;
         rt_byte  <= 8'd0;
      end else begin
         rt_valid <= byte_valid && byteClass == CLS_RT;
         if (byte_valid && byteClass == CLS_RT)
            rt_byte <= byte_data;
      end
   end
`else
   assign rt_valid = 1'b0;
   assign rt_byte  = 8'd0;
`endif

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: byte driver, message scoreboard, summary line.
module tb_midi_message_parser;

`ifdef MIDI_PARSER_REALTIME_EN
   localparam bit RT_ON = 1'b1;
`else
   localparam bit RT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;
   logic       msg_valid;
   logic [3:0] msg_type;
   logic [3:0] msg_channel;
   logic [6:0] msg_data1;
   logic [6:0] msg_data2;
   logic       rt_valid;
   logic [7:0] rt_byte;
   logic       err_pulse;
   logic [7:0] err_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_err_cnt = 0;
   logic [21:0] exp_q[$];

   midi_message_parser #(.NOTE_ON_ZERO_AS_OFF(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .msg_valid   (msg_valid),
      .msg_type    (msg_type),
      .msg_channel (msg_channel),
      .msg_data1   (msg_data1),
      .msg_data2   (msg_data2),
      .rt_valid    (rt_valid),
      .rt_byte     (rt_byte),
      .err_pulse   (err_pulse),
      .err_count   (err_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // scoreboard: every msg_valid pops one expected {type,chan,d1,d2}
   always @(negedge clk) begin
      if (!rst && msg_valid) begin
         if (exp_q.size() == 0)
            check("msg_extra", {msg_type, msg_channel, msg_data1, msg_data2}, 32'h3FFFFF);
         else
            check("msg_fields", {msg_type, msg_channel, msg_data1, msg_data2}, exp_q.pop_front());
      end
   end

   task automatic expect_msg(input logic [3:0] t, input logic [3:0] c,
                             input logic [6:0] d1, input logic [6:0] d2);
      exp_q.push_back({t, c, d1, d2});
   endtask

   task automatic drained(input string tag);
      check(tag, exp_q.size(), 0);
   endtask

   // driver: one byte, then check strobes, their width and the error counter
   task automatic send_byte(input logic [7:0] b, input logic exp_rt, input logic exp_err);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
      if (exp_err && exp_err_cnt < 255)
         exp_err_cnt++;
      check($sformatf("rt_valid_%02h", b), rt_valid, exp_rt);
      check($sformatf("err_pulse_%02h", b), err_pulse, exp_err);
      check($sformatf("err_count_%02h", b), err_count, exp_err_cnt);
      @(negedge clk);
      check($sformatf("strobe_width_%02h", b), {msg_valid, rt_valid, err_pulse}, 0);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_msg"}, {msg_valid, msg_type, msg_channel, msg_data1, msg_data2}, 0);
      check({tag, "_rt"}, {rt_valid, rt_byte}, 0);
      check({tag, "_err"}, {err_pulse, err_count}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // note on, then running-status note on with velocity 0
      expect_msg(4'h9, 4'h0, 7'h3C, 7'h64);
      send_byte(8'h90, 0, 0); send_byte(8'h3C, 0, 0); send_byte(8'h64, 0, 0);
      drained("note_on");
      expect_msg(4'h8, 4'h0, 7'h40, 7'h00);
      send_byte(8'h40, 0, 0); send_byte(8'h00, 0, 0);
      drained("running_zero_vel");

      // program change keeps running status across single data bytes
      expect_msg(4'hC, 4'h5, 7'h07, 7'h00);
      expect_msg(4'hC, 4'h5, 7'h09, 7'h00);
      send_byte(8'hC5, 0, 0); send_byte(8'h07, 0, 0); send_byte(8'h09, 0, 0);
      drained("prog_change");

      // real-time byte inside a controller message
      expect_msg(4'hB, 4'h0, 7'h07, 7'h7F);
      send_byte(8'hB0, 0, 0); send_byte(8'h07, 0, 0);
      send_byte(8'hF8, RT_ON, 0);
      check("rt_byte", rt_byte, RT_ON ? 8'hF8 : 8'h00);
      send_byte(8'h7F, 0, 0);
      drained("ctrl_rt");

      // sysex payload discarded, stray data afterwards is an error
      send_byte(8'hF0, 0, 0); send_byte(8'h41, 0, 0); send_byte(8'h10, 0, 0);
      send_byte(8'hF7, 0, 0); send_byte(8'h22, 0, 1);
      drained("sysex");

      // channel status implicitly ends sysex without error
      expect_msg(4'h8, 4'h2, 7'h30, 7'h00);
      send_byte(8'hF0, 0, 0); send_byte(8'h01, 0, 0);
      send_byte(8'h92, 0, 0); send_byte(8'h30, 0, 0); send_byte(8'h00, 0, 0);
      drained("sysex_chan");

      expect_msg(4'hE, 4'h3, 7'h00, 7'h40);
      send_byte(8'hE3, 0, 0); send_byte(8'h00, 0, 0); send_byte(8'h40, 0, 0);
      drained("pitch");

      // system common skip counts
      send_byte(8'hF2, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
      send_byte(8'h03, 0, 1);
      send_byte(8'hF3, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h06, 0, 1);
      send_byte(8'hF6, 0, 0); send_byte(8'h07, 0, 1);
      expect_msg(4'h9, 4'h5, 7'h10, 7'h20);
      send_byte(8'hF2, 0, 0); send_byte(8'h01, 0, 0);
      send_byte(8'h95, 0, 0); send_byte(8'h10, 0, 0); send_byte(8'h20, 0, 0);
      drained("skip_then_status");

      // truncated message, new running status, then reset mid-message
      expect_msg(4'h8, 4'h0, 7'h11, 7'h22);
      send_byte(8'h90, 0, 0); send_byte(8'h3C, 0, 0); send_byte(8'h80, 0, 1);
      send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0);
      drained("truncated");
      send_byte(8'h33, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      exp_err_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h22, 0, 1);
      drained("after_reset");

      // error counter saturation
      for (int i = 0; i < 258; i++)
         send_byte(8'h00, 0, 1);
      check("err_saturated", err_count, 8'hFF);
      drained("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
